// File: rtl/sau_pkg.sv
// Shared types and constant helpers for the systolic-array operand sequencer.
// Optional feature macro used across the slice: SAU_ACCUM_EN.
package sau_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StRsp
    } sau_state_e;

    // Number of FEED cycles needed to push an NxN skewed operand wave through.
    function automatic int unsigned sau_feed_cycles(input int unsigned n);
        return 3 * n - 2;
    endfunction

    // Flat element index of (r,c) in a row-major packed NxN matrix.
    function automatic int unsigned sau_elem_idx(input int unsigned r, input int unsigned c,
                                                 input int unsigned n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/sau_sequencer_if.sv
// Request/response handshake bundle between a requester and the sau_sequencer.
// req_accum exists only when SAU_ACCUM_EN is defined.
interface sau_sequencer_if #(
    parameter int unsigned MATRIX_SIZE = 2,
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned TAG_WIDTH   = 8
) ();

    localparam int unsigned MAT_W = MATRIX_SIZE * MATRIX_SIZE * DATA_SIZE;

    logic                 req_valid;
    logic                 req_ready;
    logic [MAT_W-1:0]     req_a;
    logic [MAT_W-1:0]     req_b;
    logic [TAG_WIDTH-1:0] req_tag;
`ifdef SAU_ACCUM_EN
    logic                 req_accum;
`endif
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [MAT_W-1:0]     rsp_data;
    logic [TAG_WIDTH-1:0] rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_tag,
`ifdef SAU_ACCUM_EN
        output req_accum,
`endif
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag,
`ifdef SAU_ACCUM_EN
        input  req_accum,
`endif
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );

endinterface

// File: rtl/sau_skew_feeder.sv
// Combinational diagonal-skew generator: row i / column j of the array see
// element k of their operand stream at step t = i + k (resp. j + k).
module sau_skew_feeder
    import sau_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE = 2,
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned STEP_W      = 3
) (
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] mat_a,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] mat_b,
    input  logic [STEP_W-1:0]                            step,
    input  logic                                         feed_en,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0]             arr_a,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0]             arr_b
);

    always_comb begin
        arr_a = '0;
        arr_b = '0;
        if (feed_en) begin
            for (int unsigned i = 0; i < MATRIX_SIZE; i++) begin
                for (int unsigned k = 0; k < MATRIX_SIZE; k++) begin
                    // Row i carries A[i][k]; column i carries B[k][i].
                    if (32'(step) == i + k) begin
                        arr_a[i*DATA_SIZE +: DATA_SIZE] =
                            mat_a[sau_elem_idx(i, k, MATRIX_SIZE)*DATA_SIZE +: DATA_SIZE];
                        arr_b[i*DATA_SIZE +: DATA_SIZE] =
                            mat_b[sau_elem_idx(k, i, MATRIX_SIZE)*DATA_SIZE +: DATA_SIZE];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sau_sequencer.sv
// Operand sequencer / result collector for the NxN output-stationary systolic array.
// Define SAU_ACCUM_EN to add req_accum, which skips the accumulator clear.
module sau_sequencer
    import sau_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE = 2,
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned TAG_WIDTH   = 8,
    parameter int unsigned DRAIN_LAT   = 1
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    sau_sequencer_if.slave                               bus,
    output logic                                         arr_clear,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0]             arr_a,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0]             arr_b,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] arr_result,
    output logic                                         busy
);

    localparam int unsigned MAT_W   = MATRIX_SIZE * MATRIX_SIZE * DATA_SIZE;
    localparam int unsigned STEP_W  = $clog2(3 * MATRIX_SIZE - 1);
    localparam int unsigned DRAIN_W = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
    localparam logic [STEP_W-1:0]  LAST_T     = STEP_W'(sau_feed_cycles(MATRIX_SIZE) - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_LAT - 1);

    sau_state_e           state_q, state_d;
    logic [STEP_W-1:0]    t_q, t_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [MAT_W-1:0]     a_q, b_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [MAT_W-1:0]     rsp_data_q;
    logic [TAG_WIDTH-1:0] rsp_tag_q;
    logic                 accum;
    logic                 accept;
    logic                 capture;
    logic                 feed_en;

`ifdef SAU_ACCUM_EN
    assign accum = bus.req_accum;
`else
    assign accum = 1'b0;
`endif

    assign accept  = (state_q == StIdle) && bus.req_valid;
    assign capture = (state_q == StDrain) && (drain_q == LAST_DRAIN);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.req_valid) state_d = accum ? StFeed : StClear;
            StClear: state_d = StFeed;
            StFeed:  if (t_q == LAST_T) state_d = StDrain;
            StDrain: if (drain_q == LAST_DRAIN) state_d = StRsp;
            StRsp:   if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        arr_clear     = 1'b0;
        feed_en       = 1'b0;
        busy          = 1'b1;
        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                busy          = 1'b0;
            end
            StClear: arr_clear     = 1'b1;
            StFeed:  feed_en       = 1'b1;
            StDrain: ;
            StRsp:   bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Step counters sit at zero outside their state, so entry always starts at 0.
    assign t_d     = (state_q == StFeed)  ? t_q + STEP_W'(1)      : '0;
    assign drain_d = (state_q == StDrain) ? drain_q + DRAIN_W'(1) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_q        <= '0;
            drain_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
        end else begin
            t_q     <= t_d;
            drain_q <= drain_d;
            if (accept) begin
                a_q   <= bus.req_a;
                b_q   <= bus.req_b;
                tag_q <= bus.req_tag;
            end
            if (capture) begin
                rsp_data_q <= arr_result;
                rsp_tag_q  <= tag_q;
            end
        end
    end

    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_tag  = rsp_tag_q;

    sau_skew_feeder #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .DATA_SIZE   (DATA_SIZE),
        .STEP_W      (STEP_W)
    ) u_skew_feeder (
        .mat_a   (a_q),
        .mat_b   (b_q),
        .step    (t_q),
        .feed_en (feed_en),
        .arr_a   (arr_a),
        .arr_b   (arr_b)
    );

endmodule

// File: tb/tb_sau_sequencer.sv
// Bench for sau_sequencer driving a behavioural 2x2 output-stationary array model.
// Scenario with req_accum runs only when SAU_ACCUM_EN is defined.
module tb_sau_sequencer;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 8;
    localparam int unsigned DL = 1;
    localparam int unsigned MW = N * N * DW;
    localparam int unsigned VW = N * DW;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sau_sequencer_if #(.MATRIX_SIZE(N), .DATA_SIZE(DW), .TAG_WIDTH(TW)) bus ();

    logic          arr_clear;
    logic          busy;
    logic [VW-1:0] arr_a;
    logic [VW-1:0] arr_b;
    logic [MW-1:0] arr_result;

    sau_sequencer #(
        .MATRIX_SIZE (N),
        .DATA_SIZE   (DW),
        .TAG_WIDTH   (TW),
        .DRAIN_LAT   (DL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .arr_clear  (arr_clear),
        .arr_a      (arr_a),
        .arr_b      (arr_b),
        .arr_result (arr_result),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] pack_m(input int e00, input int e01, input int e10,
                                             input int e11);
        return {32'(e11), 32'(e10), 32'(e01), 32'(e00)};
    endfunction

    function automatic logic [VW-1:0] pack_v(input int e0, input int e1);
        return {32'(e1), 32'(e0)};
    endfunction

    function automatic logic [MW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] r;
        logic [DW-1:0] s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++)
                    s = s + a[(i*N+k)*DW +: DW] * b[(k*N+j)*DW +: DW];
                r[(i*N+j)*DW +: DW] = s;
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] madd(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] r;
        for (int e = 0; e < N * N; e++) r[e*DW +: DW] = a[e*DW +: DW] + b[e*DW +: DW];
        return r;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] r;
        for (int e = 0; e < N * N; e++) r[e*DW +: DW] = DW'($urandom_range(1, 255));
        return r;
    endfunction

    // Behavioural array: a flows right, b flows down, each PE accumulates a*b.
    logic [DW-1:0] m_acc [N][N];
    logic [DW-1:0] m_a   [N][N];
    logic [DW-1:0] m_b   [N][N];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    m_acc[i][j] <= '0;
                    m_a[i][j]   <= '0;
                    m_b[i][j]   <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    logic [DW-1:0] ain;
                    logic [DW-1:0] bin;
                    ain = (j == 0) ? arr_a[i*DW +: DW] : m_a[i][(j == 0) ? 0 : j-1];
                    bin = (i == 0) ? arr_b[j*DW +: DW] : m_b[(i == 0) ? 0 : i-1][j];
                    if (arr_clear) begin
                        m_acc[i][j] <= '0;
                        m_a[i][j]   <= '0;
                        m_b[i][j]   <= '0;
                    end else begin
                        m_acc[i][j] <= m_acc[i][j] + ain * bin;
                        m_a[i][j]   <= ain;
                        m_b[i][j]   <= bin;
                    end
                end
            end
        end
    end

    always_comb begin
        arr_result = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) arr_result[(i*N+j)*DW +: DW] = m_acc[i][j];
    end

    logic cur_accum;
`ifdef SAU_ACCUM_EN
    assign cur_accum = bus.req_accum;
`else
    assign cur_accum = 1'b0;
`endif

    typedef struct {
        logic [MW-1:0] data;
        logic [TW-1:0] tag;
        int            lat;
        int            acc_cyc;
    } sb_t;

    sb_t           sb_q[$];
    int            cyc          = 0;
    int            acc_cnt      = 0;
    int            rsp_cnt      = 0;
    int            clear_cnt    = 0;
    int            acc_cyc_last = 0;
    int            acc_cyc_prev = 0;
    logic [MW-1:0] acc_ref      = '0;
    logic          rv_prev      = 1'b0;

    always @(posedge clk) cyc++;

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        sb_t e;
        if (!reset_n) begin
            sb_q.delete();
            rv_prev = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                e.data = matmul(bus.req_a, bus.req_b);
                if (cur_accum) e.data = madd(acc_ref, e.data);
                acc_ref   = e.data;
                e.tag     = bus.req_tag;
                e.lat     = cur_accum ? 3 * N + DL - 1 : 3 * N + DL;
                e.acc_cyc = cyc;
                sb_q.push_back(e);
                acc_cyc_prev = acc_cyc_last;
                acc_cyc_last = cyc;
                acc_cnt++;
            end
            if (bus.rsp_valid && !rv_prev) begin
                if (sb_q.size() == 0) check("rsp_unexpected", MW'(sb_q.size()), MW'(1));
                else check("rsp_latency", MW'(cyc - sb_q[0].acc_cyc), MW'(sb_q[0].lat));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected_hs", MW'(sb_q.size()), MW'(1));
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_tag", MW'(bus.rsp_tag), MW'(e.tag));
                    rsp_cnt++;
                end
            end
            if (arr_clear) clear_cnt++;
            rv_prev = bus.rsp_valid;
        end
    end

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_valid && bus.req_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) check("accept_timeout", MW'(ok), MW'(1));
    endtask

    task automatic wait_rsp(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (rsp_cnt >= target) ok = 1'b1;
        end
        if (!ok) check("rsp_timeout", MW'(rsp_cnt), MW'(target));
    endtask

    task automatic wait_rsp_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) check("rsp_valid_timeout", MW'(ok), MW'(1));
    endtask

    task automatic drive_req(input logic [MW-1:0] a, input logic [MW-1:0] b,
                             input logic [TW-1:0] tag);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
    endtask

    int            ea0 [4] = '{1, 2, 0, 0};
    int            ea1 [4] = '{0, 3, 4, 0};
    int            eb0 [4] = '{5, 7, 0, 0};
    int            eb1 [4] = '{0, 6, 8, 0};
    logic [MW-1:0] mat_a2, mat_b2, ident, ra, rb;
    int            n_rsp = 0;
    int            snap;
    int            hs_cyc;

    initial begin
        mat_a2        = pack_m(1, 2, 3, 4);
        mat_b2        = pack_m(5, 6, 7, 8);
        ident         = pack_m(1, 0, 0, 1);
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
`ifdef SAU_ACCUM_EN
        bus.req_accum = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_req_ready", MW'(bus.req_ready), MW'(1));
        check("rst_rsp_valid", MW'(bus.rsp_valid), MW'(0));
        check("rst_busy", MW'(busy), MW'(0));
        check("rst_arr_clear", MW'(arr_clear), MW'(0));
        check("rst_arr_a", MW'(arr_a), MW'(0));
        check("rst_arr_b", MW'(arr_b), MW'(0));
        check("rst_rsp_data", bus.rsp_data, MW'(0));
        check("rst_rsp_tag", MW'(bus.rsp_tag), MW'(0));

        // Basic product with skew sequence
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        drive_req(mat_a2, mat_b2, 8'd3);
        wait_accept();
        n_rsp++;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("clr_pulse", MW'(arr_clear), MW'(1));
        check("clr_busy", MW'(busy), MW'(1));
        check("clr_req_ready", MW'(bus.req_ready), MW'(0));
        check("clr_arr_a", MW'(arr_a), MW'(0));
        for (int s = 0; s < 4; s++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("feed_a_t%0d", s), MW'(arr_a), MW'(pack_v(ea0[s], ea1[s])));
            check($sformatf("feed_b_t%0d", s), MW'(arr_b), MW'(pack_v(eb0[s], eb1[s])));
            check($sformatf("feed_clr_t%0d", s), MW'(arr_clear), MW'(0));
        end
        wait_rsp(n_rsp);

        // Back-pressure with a second request pending
        bus.rsp_ready = 1'b0;
        drive_req(rand_mat(), rand_mat(), 8'd5);
        wait_accept();
        n_rsp++;
        @(posedge clk);
        #1 drive_req(rand_mat(), rand_mat(), 8'd9);
        wait_rsp_valid();
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            check("hold_rsp_valid", MW'(bus.rsp_valid), MW'(1));
            check("hold_req_ready", MW'(bus.req_ready), MW'(0));
            if (sb_q.size() != 0) begin
                check("hold_rsp_data", bus.rsp_data, sb_q[0].data);
                check("hold_rsp_tag", MW'(bus.rsp_tag), MW'(sb_q[0].tag));
            end else begin
                check("hold_sb_empty", MW'(sb_q.size()), MW'(1));
            end
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        snap = acc_cnt;
        @(negedge clk);
        hs_cyc = cyc;
        check("hs_req_ready", MW'(bus.req_ready), MW'(0));
        @(posedge clk);
        @(negedge clk);
        check("post_hs_req_ready", MW'(bus.req_ready), MW'(1));
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n_rsp++;
        check("second_accept_cnt", MW'(acc_cnt), MW'(snap + 1));
        check("second_accept_cyc", MW'(acc_cyc_last), MW'(hs_cyc + 1));
        wait_rsp(n_rsp);

        // Reset during FEED at t=2
        ra = rand_mat();
        rb = rand_mat();
        drive_req(ra, rb, 8'h0A);
        wait_accept();
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_feed_a", MW'(arr_a), MW'(pack_v(0, int'(ra[3*DW +: DW]))));
        check("abort_feed_b", MW'(arr_b), MW'(pack_v(0, int'(rb[3*DW +: DW]))));
        reset_n = 1'b0;
        #1;
        check("abort_busy", MW'(busy), MW'(0));
        check("abort_req_ready", MW'(bus.req_ready), MW'(1));
        check("abort_rsp_valid", MW'(bus.rsp_valid), MW'(0));
        check("abort_arr_a", MW'(arr_a), MW'(0));
        check("abort_arr_b", MW'(arr_b), MW'(0));
        check("abort_rsp_data", bus.rsp_data, MW'(0));
        check("abort_rsp_tag", MW'(bus.rsp_tag), MW'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive_req(ident, ident, 8'h0B);
        wait_accept();
        n_rsp++;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_rsp(n_rsp);
        check("abort_no_extra_rsp", MW'(rsp_cnt), MW'(n_rsp));

`ifdef SAU_ACCUM_EN
        // Accumulate onto the previous result without a clear
        drive_req(mat_a2, mat_b2, 8'd1);
        bus.req_accum = 1'b0;
        wait_accept();
        n_rsp++;
        @(posedge clk);
        #1 drive_req(ident, ident, 8'd4);
        bus.req_accum = 1'b1;
        wait_accept();
        n_rsp++;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_accum = 1'b0;
        snap = clear_cnt;
        check("accum_ref", acc_ref, pack_m(20, 22, 43, 51));
        wait_rsp(n_rsp);
        check("accum_no_clear", MW'(clear_cnt), MW'(snap));
`endif

        // Back-to-back requests with req_valid held
        drive_req(rand_mat(), rand_mat(), 8'h21);
        wait_accept();
        n_rsp++;
        @(posedge clk);
        #1 drive_req(rand_mat(), rand_mat(), 8'h22);
        wait_accept();
        n_rsp++;
        check("b2b_spacing", MW'(acc_cyc_last - acc_cyc_prev), MW'(3 * N + DL + 1));
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_rsp(n_rsp);

        check("final_sb_empty", MW'(sb_q.size()), MW'(0));
        check("final_rsp_count", MW'(rsp_cnt), MW'(n_rsp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
